// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier request arbiter.
// Contents: FSM state encoding, state width, operand and product widths.
package mult_arb_pkg;

  localparam int STATE_W = 3;
  localparam int OPND_W  = 8;
  localparam int PROD_W  = 16;

  // Codes 4..7 are unused and steer the FSM back to S_IDLE.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_RETURN = 3'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection (purely combinational).
// Ports:
//   req    - request vector, one bit per requester
//   last   - index of the most recent winner; the scan starts just after it
//   winner - one-hot winner (all zero when no request is pending)
//   index  - binary index of the winner (0 when no request is pending)
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   index
);

  // One extra bit so last + offset never overflows before the wrap.
  logic [IDX_W:0] w_cand;
  logic           w_found;

  // NOTE: combinational logic uses blocking assignments and gives every
  // output a default first, so no latch is inferred and later loop
  // iterations see earlier results.
  always_comb begin
    winner  = '0;
    index   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand = {1'b0, last} + (IDX_W+1)'(off);
      if (w_cand >= (IDX_W+1)'(NUM_REQ)) w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
      if (!w_found && req[w_cand[IDX_W-1:0]]) begin
        w_found                    = 1'b1;
        winner[w_cand[IDX_W-1:0]]  = 1'b1;
        index                      = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mult_req_arbiter.sv
// Shares one sequential 8x8 multiplier among NUM_REQ requesters.
// Round-robin arbitration, operand capture, start pulse, done-edge detection
// with a watchdog, and result return to the owning requester.
// Ports:
//   clk, reset_a              - clock (rising edge), async active-low reset
//   req                       - level request per requester
//   dataa_in, datab_in        - packed operands, requester i in [8i+7:8i]
//   gnt                       - one-hot grant, one cycle (LAUNCH)
//   res_valid                 - one-hot result strobe, one cycle (RETURN)
//   result, res_err           - product / timeout flag, held until next RETURN
//   busy, state_out           - not-idle flag and raw FSM state
//   mult_start, mult_dataa/b  - controls to the multiplier
//   mult_done, mult_product   - status from the multiplier
module mult_req_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset_a,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [OPND_W*NUM_REQ-1:0] dataa_in,
  input  logic [OPND_W*NUM_REQ-1:0] datab_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        res_valid,
  output logic [PROD_W-1:0]         result,
  output logic                      res_err,
  output logic                      busy,
  output logic [STATE_W-1:0]        state_out,
  output logic                      mult_start,
  output logic [OPND_W-1:0]         mult_dataa,
  output logic [OPND_W-1:0]         mult_datab,
  input  logic                      mult_done,
  input  logic [PROD_W-1:0]         mult_product
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TW    = $clog2(TIMEOUT + 1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_owner;
  logic [IDX_W-1:0]    r_last;
  logic [TW-1:0]       r_timer;
  logic                r_done_q;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_res_valid;
  logic [PROD_W-1:0]   r_result;
  logic                r_res_err;
  logic                r_mult_start;
  logic [OPND_W-1:0]   r_mult_dataa;
  logic [OPND_W-1:0]   r_mult_datab;

  logic [NUM_REQ-1:0]  w_win_oh;
  logic [IDX_W-1:0]    w_win_idx;
  logic [NUM_REQ-1:0]  w_owner_oh;
  logic                w_done_rise;
  logic                w_timeout;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req    (req),
    .last   (r_last),
    .winner (w_win_oh),
    .index  (w_win_idx)
  );

  assign w_owner_oh  = NUM_REQ'(1) << r_owner;
  // Only a rising done counts, so a level left high by the previous
  // operation cannot complete the current one.
  assign w_done_rise = mult_done & ~r_done_q;
  assign w_timeout   = (r_timer == TW'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last       <= IDX_W'(NUM_REQ - 1);
      r_timer      <= '0;
      r_done_q     <= 1'b0;
      r_gnt        <= '0;
      r_res_valid  <= '0;
      r_result     <= '0;
      r_res_err    <= 1'b0;
      r_mult_start <= 1'b0;
      r_mult_dataa <= '0;
      r_mult_datab <= '0;
    end else begin
      r_done_q     <= mult_done;
      // Strobes default low; they are raised only on entry to their state.
      r_gnt        <= '0;
      r_mult_start <= 1'b0;
      r_res_valid  <= '0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_mult_dataa <= dataa_in[OPND_W*int'(w_win_idx) +: OPND_W];
            r_mult_datab <= datab_in[OPND_W*int'(w_win_idx) +: OPND_W];
            r_owner      <= w_win_idx;
            r_last       <= w_win_idx;
            r_gnt        <= w_win_oh;
            r_mult_start <= 1'b1;
            r_state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion has priority over a simultaneous timeout.
          if (w_done_rise) begin
            r_result    <= mult_product;
            r_res_err   <= 1'b0;
            r_res_valid <= w_owner_oh;
            r_state     <= S_RETURN;
          end else if (w_timeout) begin
            r_result    <= '0;
            r_res_err   <= 1'b1;
            r_res_valid <= w_owner_oh;
            r_state     <= S_RETURN;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_RETURN: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign res_valid  = r_res_valid;
  assign result     = r_result;
  assign res_err    = r_res_err;
  assign busy       = (r_state != S_IDLE);
  assign state_out  = r_state;
  assign mult_start = r_mult_start;
  assign mult_dataa = r_mult_dataa;
  assign mult_datab = r_mult_datab;

endmodule
